// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate select encodings and sign-extension helper
package imm_pkg;

    localparam int IMM_SEL_W = 3;

    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_U_TYPE       = 3'd0,
        IMM_J_TYPE       = 3'd1,
        IMM_I_TYPE       = 3'd2,
        IMM_S_TYPE       = 3'd3,
        IMM_B_TYPE       = 3'd4,
        IMM_CSR_UIMM     = 3'd5,
        IMM_SHAMT        = 3'd6,
        IMM_UNKNOWN_TYPE = 3'd7
    } imm_sel_e;

    // value must be zero above sign_bit; the result is the 64-bit sign extension from sign_bit
    function automatic logic [63:0] sign_extend(input logic [31:0] value, input logic [4:0] sign_bit);
        logic [63:0] fill;
        fill = {64{value[sign_bit]}} << sign_bit;
        return fill | {32'b0, value};
    endfunction

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction for RV32/RV64
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IMM_SEL_W-1:0] sel,
    input  logic [31:7]          instr,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    logic [63:0] imm_full;

    always_comb begin
        imm_full = '0;
        illegal  = 1'b0;
        case (sel)
            IMM_U_TYPE:   imm_full = sign_extend({instr[31:12], 12'b0}, 5'd31);
            IMM_J_TYPE:   imm_full = sign_extend({11'b0, instr[31], instr[19:12], instr[20],
                                                  instr[30:21], 1'b0}, 5'd20);
            IMM_I_TYPE:   imm_full = sign_extend({20'b0, instr[31:20]}, 5'd11);
            IMM_S_TYPE:   imm_full = sign_extend({20'b0, instr[31:25], instr[11:7]}, 5'd11);
            IMM_B_TYPE:   imm_full = sign_extend({19'b0, instr[31], instr[7], instr[30:25],
                                                  instr[11:8], 1'b0}, 5'd12);
            IMM_CSR_UIMM: imm_full = {59'b0, instr[19:15]};
            IMM_SHAMT:    imm_full = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            default:      illegal  = 1'b1;
        endcase
    end

    assign imm = imm_full[XLEN-1:0];

    if (XLEN == 32) begin : g_rv32
        logic unused_upper;
        assign unused_upper = ^imm_full[63:32];
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - two-stage immediate generator with PC-relative target
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit ENABLE_TARGET = 1'b1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Flush,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic [IMM_SEL_W-1:0] i_Imm_Select,
    input  logic [24:0]          i_Instruction_No_Opcode,
    input  logic [XLEN-1:0]      i_PC,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [XLEN-1:0]      o_Immediate,
    output logic [XLEN-1:0]      o_Target,
    output logic                 o_Illegal
);

    logic                 s1_valid_q, s1_valid_d;
    logic [IMM_SEL_W-1:0] s1_sel_q, s1_sel_d;
    logic [31:7]          s1_instr_q, s1_instr_d;
    logic [XLEN-1:0]      s1_pc_q, s1_pc_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]      s2_imm_q, s2_imm_d;
    logic [XLEN-1:0]      s2_target_q, s2_target_d;
    logic                 s2_illegal_q, s2_illegal_d;

    logic                 s2_accept;
    logic                 in_fire;
    logic [XLEN-1:0]      ext_imm;
    logic                 ext_illegal;
    logic [XLEN-1:0]      target_sum;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .sel     (s1_sel_q),
        .instr   (s1_instr_q),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    if (ENABLE_TARGET) begin : g_target
        assign target_sum = s1_pc_q + ext_imm;
    end else begin : g_no_target
        logic unused_pc;
        assign target_sum = '0;
        assign unused_pc  = ^s1_pc_q;
    end

    // S2 can take a new entry when empty or when its current entry leaves this edge
    assign s2_accept = !s2_valid_q || i_Ready;
    assign o_Ready   = !i_Reset && !i_Flush && (!s1_valid_q || s2_accept);
    assign in_fire   = i_Valid && o_Ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sel_d     = s1_sel_q;
        s1_instr_d   = s1_instr_q;
        s1_pc_d      = s1_pc_q;
        s2_valid_d   = s2_valid_q;
        s2_imm_d     = s2_imm_q;
        s2_target_d  = s2_target_q;
        s2_illegal_d = s2_illegal_q;

        if (in_fire) begin
            s1_sel_d   = i_Imm_Select;
            s1_instr_d = i_Instruction_No_Opcode;
            s1_pc_d    = i_PC;
        end
        if (o_Ready) begin
            s1_valid_d = i_Valid;
        end
        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_d     = ext_imm;
                s2_target_d  = target_sum;
                s2_illegal_d = ext_illegal;
            end
        end
        // Flush wins over any concurrent output transfer
        if (i_Flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            s1_valid_q   <= 1'b0;
            s1_sel_q     <= '0;
            s1_instr_q   <= '0;
            s1_pc_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_imm_q     <= '0;
            s2_target_q  <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sel_q     <= s1_sel_d;
            s1_instr_q   <= s1_instr_d;
            s1_pc_q      <= s1_pc_d;
            s2_valid_q   <= s2_valid_d;
            s2_imm_q     <= s2_imm_d;
            s2_target_q  <= s2_target_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign o_Valid     = s2_valid_q;
    assign o_Immediate = s2_imm_q;
    assign o_Target    = s2_target_q;
    assign o_Illegal   = s2_illegal_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (RV32 and RV64)
module tb_imm_gen_pipe;
    import imm_pkg::*;

    typedef struct {
        logic [IMM_SEL_W-1:0] sel;
        logic [31:0]          instr;
        logic [63:0]          pc;
        logic [63:0]          imm;
        logic [63:0]          tgt;
        logic                 ill;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush, in_valid, out_ready;
    logic [IMM_SEL_W-1:0] sel;
    logic [31:0]          instr, pc;
    logic                 in_ready, out_valid, ill;
    logic [31:0]          imm, tgt;

    logic                 flush64, in_valid64, out_ready64;
    logic [IMM_SEL_W-1:0] sel64;
    logic [31:0]          instr64;
    logic [63:0]          pc64;
    logic                 in_ready64, out_valid64, ill64;
    logic [63:0]          imm64, tgt64;

    int checks   = 0;
    int failures = 0;

    vec_t v32[8];
    vec_t v64[8];
    logic [31:0] got_q[$];
    int sent;

    imm_gen_pipe #(.XLEN(32), .ENABLE_TARGET(1'b1)) dut32 (
        .i_Clock(clk), .i_Reset(rst), .i_Flush(flush),
        .i_Valid(in_valid), .o_Ready(in_ready),
        .i_Imm_Select(sel), .i_Instruction_No_Opcode(instr[31:7]), .i_PC(pc),
        .o_Valid(out_valid), .i_Ready(out_ready),
        .o_Immediate(imm), .o_Target(tgt), .o_Illegal(ill)
    );

    imm_gen_pipe #(.XLEN(64), .ENABLE_TARGET(1'b1)) dut64 (
        .i_Clock(clk), .i_Reset(rst), .i_Flush(flush64),
        .i_Valid(in_valid64), .o_Ready(in_ready64),
        .i_Imm_Select(sel64), .i_Instruction_No_Opcode(instr64[31:7]), .i_PC(pc64),
        .o_Valid(out_valid64), .i_Ready(out_ready64),
        .o_Immediate(imm64), .o_Target(tgt64), .o_Illegal(ill64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_i32(input logic v, input logic [31:0] ins, input logic [31:0] p);
        in_valid = v;
        sel      = IMM_I_TYPE;
        instr    = ins;
        pc       = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        v32[0] = '{IMM_I_TYPE,       32'hFFF00093, 64'h100,  64'hFFFFFFFF, 64'hFF,       1'b0};
        v32[1] = '{IMM_B_TYPE,       32'hFE000EE3, 64'h0,    64'hFFFFFFFC, 64'hFFFFFFFC, 1'b0};
        v32[2] = '{IMM_J_TYPE,       32'h0080006F, 64'h20,   64'h8,        64'h28,       1'b0};
        v32[3] = '{IMM_S_TYPE,       32'h00112623, 64'h40,   64'hC,        64'h4C,       1'b0};
        v32[4] = '{IMM_U_TYPE,       32'h12345037, 64'h1000, 64'h12345000, 64'h12346000, 1'b0};
        v32[5] = '{IMM_CSR_UIMM,     32'hFFFFF073, 64'h0,    64'h1F,       64'h1F,       1'b0};
        v32[6] = '{IMM_UNKNOWN_TYPE, 32'hFFFFFFFF, 64'h80,   64'h0,        64'h80,       1'b1};
        v32[7] = '{IMM_SHAMT,        32'h03F00013, 64'h0,    64'h1F,       64'h1F,       1'b0};

        v64[0] = '{IMM_I_TYPE,       32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'hFF, 1'b0};
        v64[1] = '{IMM_U_TYPE,       32'h80000037, 64'h0,   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0};
        v64[2] = '{IMM_SHAMT,        32'h03F00013, 64'h10,  64'h3F, 64'h4F, 1'b0};
        v64[3] = '{IMM_B_TYPE,       32'hFE000EE3, 64'h0,   64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        v64[4] = '{IMM_J_TYPE,       32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h4, 1'b0};
        v64[5] = '{IMM_CSR_UIMM,     32'hFFFFF073, 64'h0,   64'h1F, 64'h1F, 1'b0};
        v64[6] = '{IMM_UNKNOWN_TYPE, 32'h00000000, 64'h8,   64'h0,  64'h8,  1'b1};
        v64[7] = '{IMM_I_TYPE,       32'h7FF00093, 64'h0,   64'h7FF, 64'h7FF, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = '0; instr = '0; pc = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1;
        sel64 = '0; instr64 = '0; pc64 = '0;

        // reset state
        @(negedge clk);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_ready", {63'b0, in_ready}, 64'd0);
        check("rst_imm", {32'b0, imm}, 64'd0);
        check("rst_tgt", {32'b0, tgt}, 64'd0);
        check("rst_ill", {63'b0, ill}, 64'd0);
        check("rst_valid64", {63'b0, out_valid64}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'b0, in_ready}, 64'd1);
        check("post_rst_ready64", {63'b0, in_ready64}, 64'd1);

        // back-to-back vectors on both widths, checked two cycles after issue
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; sel = v32[k].sel; instr = v32[k].instr; pc = v32[k].pc[31:0];
                in_valid64 = 1'b1; sel64 = v64[k].sel; instr64 = v64[k].instr; pc64 = v64[k].pc;
            end else begin
                in_valid = 1'b0; in_valid64 = 1'b0;
            end
            if (k < 2) begin
                check($sformatf("lat_k%0d_valid", k), {63'b0, out_valid}, 64'd0);
            end else begin
                check($sformatf("v32_%0d_valid", k-2), {63'b0, out_valid}, 64'd1);
                check($sformatf("v32_%0d_imm", k-2), {32'b0, imm}, v32[k-2].imm);
                check($sformatf("v32_%0d_tgt", k-2), {32'b0, tgt}, v32[k-2].tgt);
                check($sformatf("v32_%0d_ill", k-2), {63'b0, ill}, {63'b0, v32[k-2].ill});
                check($sformatf("v64_%0d_valid", k-2), {63'b0, out_valid64}, 64'd1);
                check($sformatf("v64_%0d_imm", k-2), imm64, v64[k-2].imm);
                check($sformatf("v64_%0d_tgt", k-2), tgt64, v64[k-2].tgt);
                check($sformatf("v64_%0d_ill", k-2), {63'b0, ill64}, {63'b0, v64[k-2].ill});
            end
            step();
        end
        check("drained_valid", {63'b0, out_valid}, 64'd0);

        // backpressure: 4 entries, consumer stalls for 3 cycles once both stages fill
        sent = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 4) drive_i32(1'b1, {12'(sent + 1), 20'h00093}, 32'h1000);
            else          in_valid = 1'b0;
            #1;
            if (c >= 2 && c <= 4) begin
                check($sformatf("bp_c%0d_ready", c), {63'b0, in_ready}, 64'd0);
                check($sformatf("bp_c%0d_valid", c), {63'b0, out_valid}, 64'd1);
                check($sformatf("bp_c%0d_imm", c), {32'b0, imm}, 64'h1);
                check($sformatf("bp_c%0d_tgt", c), {32'b0, tgt}, 64'h1001);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got_q.push_back(imm);
            step();
        end
        out_ready = 1'b1;
        check("bp_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            check($sformatf("bp_order_%0d", i), {32'b0, got_q[i]}, 64'(i + 1));
        end

        // flush with both stages full and a simultaneous output accept
        drive_i32(1'b1, 32'h01100093, 32'h2000); out_ready = 1'b0;
        step();
        drive_i32(1'b1, 32'h02200093, 32'h2000);
        step();
        check("fl_full_imm", {32'b0, imm}, 64'h11);
        drive_i32(1'b1, 32'h03300093, 32'h2000); flush = 1'b1; out_ready = 1'b1;
        #1;
        check("fl_ready_low", {63'b0, in_ready}, 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid_after", {63'b0, out_valid}, 64'd0);
        step();
        check("fl_valid_after2", {63'b0, out_valid}, 64'd0);
        drive_i32(1'b1, 32'h04400093, 32'h2000);
        step();
        in_valid = 1'b0;
        step();
        check("fl_rec_valid", {63'b0, out_valid}, 64'd1);
        check("fl_rec_imm", {32'b0, imm}, 64'h44);
        check("fl_rec_tgt", {32'b0, tgt}, 64'h2044);
        step();

        // asynchronous reset in the middle of a stream
        drive_i32(1'b1, 32'h01100093, 32'h3000);
        step();
        drive_i32(1'b1, 32'h02200093, 32'h3000);
        step();
        drive_i32(1'b1, 32'h03300093, 32'h3000);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", {63'b0, out_valid}, 64'd0);
        check("ar_imm", {32'b0, imm}, 64'd0);
        check("ar_tgt", {32'b0, tgt}, 64'd0);
        check("ar_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("ar_rel_ready", {63'b0, in_ready}, 64'd1);
        check("ar_rel_valid", {63'b0, out_valid}, 64'd0);
        drive_i32(1'b1, 32'h05500093, 32'h3000);
        step();
        in_valid = 1'b0;
        step();
        check("ar_rec_valid", {63'b0, out_valid}, 64'd1);
        check("ar_rec_imm", {32'b0, imm}, 64'h55);
        check("ar_rec_tgt", {32'b0, tgt}, 64'h3055);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode path.
- Accepts {immediate select, instruction bits [XLEN_INSTR-1:7], PC} over a valid/ready handshake.
- Produces the sign- or zero-extended immediate for RV32 or RV64, plus a registered PC-relative target (PC + imm) for branch/jump/AUIPC, two cycles later.
- Adds CSR-uimm and shift-amount modes, flush, an illegal-select flag, and full-throughput backpressure handling.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ENABLE_TARGET, 1, when 0 the o_Target adder is removed and o_Target is tied to 0.

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  reset; asynchronous, active-high.
- i_Flush  in  1  drop all in-flight entries.
- i_Valid  in  1  input entry valid.
- o_Ready  out  1  block can accept the input this cycle.
- i_Imm_Select  in  IMM_SEL_W  immediate type, encoded per package.
- i_Instruction_No_Opcode  in  25  instruction bits [31:7].
- i_PC  in  XLEN  PC of the instruction.
- o_Valid  out  1  output entry valid.
- i_Ready  in  1  consumer accepts output.
- o_Immediate  out  XLEN  extended immediate.
- o_Target  out  XLEN  i_PC + immediate, modulo 2^XLEN.
- o_Illegal  out  1  select was IMM_UNKNOWN_TYPE or unencoded.

Behaviour:
- Reset is asynchronous, active-high, one clock. Under reset, both stage valid bits, o_Valid, o_Immediate, o_Target and o_Illegal are 0. o_Ready is 0 while i_Reset is high and 1 in the first cycle after release.
- Stage S1 registers select, instruction and PC. Stage S2 registers the computed immediate, target and illegal flag. Outputs come directly from S2 registers.
- Latency: an entry accepted at edge N is presented on o_Valid after edge N+2 when there is no stall. Throughput is one entry per cycle.
- Handshake:
  - Transfer occurs on a rising edge where valid && ready.
  - S2 holds while o_Valid && !i_Ready. S1 advances when S2 is empty or S2 is draining.
  - o_Ready = !S1_valid || S1_advance. A combinational path from i_Ready is permitted.
  - Held output data are stable while o_Valid && !i_Ready.
- Immediate modes, where b = i_Instruction_No_Opcode indexed by instruction bit number:
  - U: {b[31:12], 12'b0}, sign-extended to XLEN (matters for RV64).
  - J: sext({b31, b19:12, b20, b30:21, 0}).
  - I: sext(b31:20).
  - S: sext({b31:25, b11:7}).
  - B: sext({b31, b7, b30:25, b11:8, 0}).
  - CSR_UIMM: zext(b19:15).
  - SHAMT: zext(b24:20) when XLEN=32; zext(b25:20) when XLEN=64.
  - UNKNOWN or any unencoded value: immediate 0, o_Illegal = 1. The entry still flows through the pipeline.
- o_Target is computed in S2 for every mode; the consumer ignores it where meaningless. Carry out of bit XLEN-1 is discarded, so wrap-around is silent.
- Flush:
  - i_Flush high at an edge clears both valid bits; held data are don't-care.
  - o_Ready is 0 while i_Flush is high, so no input is accepted that cycle.
  - Flush takes priority over a simultaneous output transfer; the output is considered not accepted.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

Decomposition:
- Shared package imm_pkg:
  - IMM_SEL_W = 3.
  - Select encodings: IMM_U_TYPE, IMM_J_TYPE, IMM_I_TYPE, IMM_S_TYPE, IMM_B_TYPE, IMM_CSR_UIMM, IMM_SHAMT, IMM_UNKNOWN_TYPE.
  - Sign-extend helper function.
- One combinational sub-module, imm_extract (XLEN-parametrised), maps select plus bits to {immediate, illegal}. It is instantiated between S1 and S2. The top holds the pipeline control and the adder.

Test Plan:
- XLEN=32, I-type 0xFFF00093, PC=0x100 -> 2 cycles later o_Immediate=0xFFFFFFFF, o_Target=0x000000FF, o_Illegal=0.
- B-type 0xFE000EE3 at PC=0x0, then J-type 0x0080006F at PC=0x20, back-to-back -> imm 0xFFFFFFFC with target 0xFFFFFFFC (wrap), then imm 0x8 with target 0x28 on consecutive cycles.
- S-type 0x00112623 -> imm 0xC. U-type 0x12345037 -> 0x12345000. CSR_UIMM with b19:15=31 -> 0x1F. UNKNOWN select -> imm 0, o_Illegal=1.
- XLEN=64: I-type 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; U-type 0x80000037 -> 0xFFFFFFFF80000000; SHAMT with b25:20=63 -> 0x3F.
- Backpressure: stream 4 entries with i_Valid held high, hold i_Ready=0 for 3 cycles -> o_Ready falls once S1 and S2 are full, no entry lost or duplicated, output order preserved, o_* stable while stalled.
- i_Flush pulsed with both stages full, and separately i_Reset asserted mid-stream -> o_Valid=0 at the next edge (reset: immediately), o_Ready=0 during the flush cycle, first entry after recovery emerges with correct data.
